// File: rtl/leaf_launch_ctrl.sv
// Multi-channel launch detector: synchronises level inputs, detects per-channel edges and emits a
// one-cycle pulse plus a stretched reset. Optional saturating launch counters via LEAF_LAUNCH_CNT_EN.
module leaf_launch_ctrl #(
    parameter int unsigned NUM_CH      = 1,
    parameter int unsigned SYNC_STAGES = 1,
    parameter int unsigned RST_HOLD    = 4,
    parameter int unsigned CNT_BITS    = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CH-1:0]            din,
    input  logic [2*NUM_CH-1:0]          mode,
    input  logic                         clr_cnt,
    output logic [NUM_CH-1:0]            edge_out,
    output logic [NUM_CH-1:0]            rst_out,
    output logic [NUM_CH-1:0]            level_out,
    output logic [CNT_BITS*NUM_CH-1:0]   launch_cnt
);

    localparam int unsigned HoldW = $clog2(RST_HOLD + 1);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(RST_HOLD);

    logic [NUM_CH-1:0] qual;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic                   edge_q;
        logic                   rst_q;
        logic [HoldW-1:0]       hold_q;
        logic [HoldW-1:0]       hold_d;
        logic                   cur;
        logic                   rise;
        logic                   fall;
        logic [1:0]             ch_mode;

        assign cur     = sync_q[SYNC_STAGES-1];
        assign ch_mode = mode[2*ch +: 2];

        // Mode 00 masks both terms, so a disabled channel keeps tracking history silently.
        always_comb begin
            rise     = cur & ~prev_q;
            fall     = ~cur & prev_q;
            qual[ch] = (ch_mode[0] & rise) | (ch_mode[1] & fall);
        end

        always_comb begin
            hold_d = hold_q;
            if (qual[ch]) begin
                hold_d = HoldLoad;
            end else if (hold_q != '0) begin
                hold_d = hold_q - HoldW'(1);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= '0;
                prev_q <= 1'b0;
                edge_q <= 1'b0;
                hold_q <= '0;
                rst_q  <= 1'b0;
            end else begin
                sync_q <= (sync_q << 1) | SYNC_STAGES'(din[ch]);
                prev_q <= cur;
                edge_q <= qual[ch];
                hold_q <= hold_d;
                rst_q  <= (hold_d != '0);
            end
        end

        assign edge_out[ch]  = edge_q;
        assign rst_out[ch]   = rst_q;
        assign level_out[ch] = cur;
    end

`ifdef LEAF_LAUNCH_CNT_EN
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_cnt
        logic [CNT_BITS-1:0] cnt_q;
        logic [CNT_BITS-1:0] cnt_d;

        // Clear wins over a coincident increment; the count sticks at all-ones.
        always_comb begin
            cnt_d = cnt_q;
            if (clr_cnt) begin
                cnt_d = '0;
            end else if (qual[ch] && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_BITS'(1);
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign launch_cnt[CNT_BITS*ch +: CNT_BITS] = cnt_q;
    end
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign launch_cnt     = '0;
`endif

endmodule

// File: tb/tb_leaf_launch_ctrl.sv
// Self-checking bench for leaf_launch_ctrl: per-cycle comparison against an array-based model of
// the edge/hold/count rules, plus directed literal expectations for each scenario.
module tb_leaf_launch_ctrl;

    localparam int NCH  = 3;
    localparam int SS   = 2;
    localparam int RH   = 4;
    localparam int CB   = 2;
    localparam int MAXC = 4096;
`ifdef LEAF_LAUNCH_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH-1:0]    din = '0;
    logic [2*NCH-1:0]  mode = '0;
    logic              clr_cnt = 1'b0;
    logic [NCH-1:0]    edge_out;
    logic [NCH-1:0]    rst_out;
    logic [NCH-1:0]    level_out;
    logic [CB*NCH-1:0] launch_cnt;

    always #5 clk = ~clk;

    leaf_launch_ctrl #(
        .NUM_CH     (NCH),
        .SYNC_STAGES(SS),
        .RST_HOLD   (RH),
        .CNT_BITS   (CB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (din),
        .mode      (mode),
        .clr_cnt   (clr_cnt),
        .edge_out  (edge_out),
        .rst_out   (rst_out),
        .level_out (level_out),
        .launch_cnt(launch_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Model: everything sampled at clock edge k is kept by index; outputs are derived from history.
    logic [NCH-1:0]   din_s  [MAXC];
    logic [2*NCH-1:0] mode_s [MAXC];
    int               n = 0;
    int               start = 0;
    int               cnt_m [NCH];

    function automatic int lvl(input int ch, input int k);
        int idx;
        idx = k - SS + 1;
        if (idx < start) return 0;
        return int'(din_s[idx][ch]);
    endfunction

    function automatic int edg(input int ch, input int k);
        logic [1:0] m;
        int a, b;
        if (k < start) return 0;
        m = mode_s[k][2*ch +: 2];
        a = lvl(ch, k - 1);
        b = lvl(ch, k - 2);
        return ((m[0] && a == 1 && b == 0) || (m[1] && a == 0 && b == 1)) ? 1 : 0;
    endfunction

    function automatic int rst_exp(input int ch, input int k);
        for (int j = k - RH + 1; j <= k; j++) begin
            if (j >= start && edg(ch, j) == 1) return 1;
        end
        return 0;
    endfunction

    always @(posedge clk) begin : model
        int  cur;
        bit  in_rst;
        in_rst = !reset_n;
        if (in_rst) begin
            start = n + 1;
            for (int ch = 0; ch < NCH; ch++) cnt_m[ch] = 0;
        end else begin
            din_s[n]  = din;
            mode_s[n] = mode;
            for (int ch = 0; ch < NCH; ch++) begin
                if (clr_cnt) cnt_m[ch] = 0;
                else if (edg(ch, n) == 1 && cnt_m[ch] < (1 << CB) - 1) cnt_m[ch]++;
            end
        end
        cur = n;
        n   = n + 1;
        #1;
        for (int ch = 0; ch < NCH; ch++) begin
            chk($sformatf("cyc%0d ch%0d edge_out", cur, ch), int'(edge_out[ch]),
                in_rst ? 0 : edg(ch, cur));
            chk($sformatf("cyc%0d ch%0d rst_out", cur, ch), int'(rst_out[ch]),
                in_rst ? 0 : rst_exp(ch, cur));
            chk($sformatf("cyc%0d ch%0d level_out", cur, ch), int'(level_out[ch]),
                in_rst ? 0 : lvl(ch, cur));
            chk($sformatf("cyc%0d ch%0d launch_cnt", cur, ch), int'(launch_cnt[CB*ch +: CB]),
                (in_rst || CNT_ON == 0) ? 0 : cnt_m[ch]);
        end
    end

    logic [6:0] t1_l, t1_e, t1_r;
    logic [9:0] t2_e, t2_r;
    logic [5:0] t4_e;
    int         pulses, pulses1, rsts1;

    initial begin
        t1_l = 7'b1111110;
        t1_e = 7'b0000100;
        t1_r = 7'b0111100;
        t2_e = 10'b0000010100;
        t2_r = 10'b0011111100;
        t4_e = 6'b000100;

        repeat (3) @(negedge clk);
        chk("reset edge_out", int'(edge_out), 0);
        chk("reset rst_out", int'(rst_out), 0);
        chk("reset level_out", int'(level_out), 0);
        chk("reset launch_cnt", int'(launch_cnt), 0);
        reset_n = 1'b1;
        mode    = {2'b11, 2'b10, 2'b01};
        repeat (4) @(negedge clk);

        // Rise, basic on ch0.
        din[0] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("rise level off%0d", i), int'(level_out[0]), int'(t1_l[i]));
            chk($sformatf("rise edge off%0d", i), int'(edge_out[0]), int'(t1_e[i]));
            chk($sformatf("rise rst off%0d", i), int'(rst_out[0]), int'(t1_r[i]));
        end

        // Both-mode retrigger on ch2: two toggles 2 cycles apart.
        din[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("both edge off%0d", i), int'(edge_out[2]), int'(t2_e[i]));
            chk($sformatf("both rst off%0d", i), int'(rst_out[2]), int'(t2_r[i]));
            if (i == 1) din[2] = 1'b0;
        end

        // Disable then enable on ch0.
        din[0] = 1'b0;
        repeat (6) @(negedge clk);
        mode[1:0] = 2'b00;
        din[0]    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("disabled edge off%0d", i), int'(edge_out[0]), 0);
            chk($sformatf("disabled rst off%0d", i), int'(rst_out[0]), 0);
        end
        mode[1:0] = 2'b01;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("enabled edge off%0d", i), int'(edge_out[0]), 0);
            chk($sformatf("enabled rst off%0d", i), int'(rst_out[0]), 0);
        end
        din[0] = 1'b0;
        repeat (3) @(negedge clk);
        din[0] = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pulses += int'(edge_out[0]);
        end
        chk("reenable pulse count", pulses, 1);

        // din held high through reset release: rise on ch0, nothing on fall-mode ch1.
        din[1] = 1'b1;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("release ch0 edge off%0d", i), int'(edge_out[0]), int'(t4_e[i]));
            chk($sformatf("release ch1 edge off%0d", i), int'(edge_out[1]), 0);
        end

        // Reset in the middle of a hold drops rst_out at once.
        din[0] = 1'b0;
        repeat (4) @(negedge clk);
        din[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("midhold rst before reset", int'(rst_out[0]), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midhold rst after reset", int'(rst_out[0]), 0);
        chk("midhold level after reset", int'(level_out[0]), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        // Counter: clear, six rises saturating at 3, then clear coincident with a 7th edge.
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din[0] = 1'b0;
            repeat (3) @(negedge clk);
            din[0] = 1'b1;
            repeat (3) @(negedge clk);
            chk($sformatf("count after rise %0d", i + 1), int'(launch_cnt[CB-1:0]),
                CNT_ON * ((i + 1 < 3) ? i + 1 : 3));
        end
        din[0] = 1'b0;
        repeat (3) @(negedge clk);
        din[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        chk("clr vs edge: edge_out", int'(edge_out[0]), 1);
        chk("clr vs edge: launch_cnt", int'(launch_cnt[CB-1:0]), 0);

        // Multi-channel independence: only ch1 (fall mode) sees a toggle.
        repeat (8) @(negedge clk);
        din[1]  = 1'b0;
        pulses1 = 0;
        rsts1   = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pulses1 += int'(edge_out[1]);
            rsts1   += int'(rst_out[1]);
            chk($sformatf("indep ch0/ch2 edge off%0d", i), int'({edge_out[2], edge_out[0]}), 0);
            chk($sformatf("indep ch0/ch2 rst off%0d", i), int'({rst_out[2], rst_out[0]}), 0);
        end
        chk("indep ch1 pulse count", pulses1, 1);
        chk("indep ch1 rst cycles", rsts1, RH);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
